// File: rtl/sdram_command_pkg.sv
// Shared definitions for the SDRAM command interface.
// Imported by the frame arbiter (initiator) and by sdram_burst_responder.
// Holds the command encoding, the responder state enum and the default
// burst lengths used by both ends of the link.
package sdram_command_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE     = 2'd0,
        CMD_WRITE    = 2'd1,
        CMD_READ     = 2'd2,
        CMD_RESERVED = 2'd3
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_READ      = 3'd3,
        ST_HOLD      = 3'd4,
        ST_REFRESH   = 3'd5
    } responder_state_e;

    localparam int DEFAULT_READ_BURST_LENGTH  = 8;
    localparam int DEFAULT_WRITE_BURST_LENGTH = 8;

endpackage

// File: rtl/burst_ram.sv
// Simple dual-port block RAM backing the burst responder.
// Ports:
//   clk        clock
//   rst_n      async active-low reset, clears only the read output register
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write word
//   rd_en_i    read strobe; the output register only loads when set
//   rd_addr_i  read address
//   rd_data_o  registered read word (1-cycle latency), holds between reads
module burst_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdData_q;

    // Storage is never reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // The output register doubles as the interface data_read register, so it
    // is reset to 0 and keeps its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            rdData_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/sdram_burst_responder.sv
// Block-RAM stand-in for the external SDRAM controller.
// Answers write and read bursts from the frame arbiter with SDRAM-like
// latency, write pacing and periodic refresh stalls.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   command           0 idle, 1 write burst, 2 read burst, 3 treated as idle
//   data_address      burst base address, held for the whole burst
//   data_write        write word, sampled at the end of each done cycle
//   data_read         registered read word
//   data_read_valid   one pulse per read beat
//   data_write_done   one pulse per accepted write beat
//   refresh_active    high while a refresh stall is in progress
module sdram_burst_responder
    import sdram_command_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 22,
    parameter int MEM_ADDR_WIDTH     = 12,
    parameter int READ_BURST_LENGTH  = DEFAULT_READ_BURST_LENGTH,
    parameter int WRITE_BURST_LENGTH = DEFAULT_WRITE_BURST_LENGTH,
    parameter int READ_LATENCY       = 3,
    parameter int WRITE_GAP          = 2,
    parameter int REFRESH_INTERVAL   = 1092,
    parameter int REFRESH_CYCLES     = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            command,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  data_read_valid,
    output logic                  data_write_done,
    output logic                  refresh_active
);

    localparam int MAX_BURST = (READ_BURST_LENGTH > WRITE_BURST_LENGTH) ?
                               READ_BURST_LENGTH : WRITE_BURST_LENGTH;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int GAP_W  = $clog2(WRITE_GAP + 1);
    localparam int WAIT_W = $clog2(READ_LATENCY + 1);
    localparam int REF_W  = $clog2(REFRESH_INTERVAL + 1);
    localparam int RCY_W  = $clog2(REFRESH_CYCLES + 1);

    responder_state_e          state_q, state_d;
    sdram_cmd_e                burstCmd_q, burstCmd_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [BEAT_W-1:0]         beatCnt_q, beatCnt_d;
    logic [GAP_W-1:0]          gapCnt_q, gapCnt_d;
    logic [WAIT_W-1:0]         waitCnt_q, waitCnt_d;
    logic [RCY_W-1:0]          refCyc_q, refCyc_d;
    logic [REF_W-1:0]          refCnt_q;
    logic                      refPending_q;

    sdram_cmd_e                cmdIn;
    logic                      burstActive;
    logic                      clearPending;
    logic [MEM_ADDR_WIDTH-1:0] memAddr;
    logic                      ramWrEn;
    logic                      ramRdEn;
    logic [MEM_ADDR_WIDTH-1:0] ramRdAddr;
    logic                      doneOut;
    logic                      validOut;

    // Upper address bits select nothing in the small backing RAM.
    logic unusedAddrBits;
    assign unusedAddrBits = ^data_address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    assign cmdIn       = sdram_cmd_e'(command);
    assign burstActive = (cmdIn == burstCmd_q);
    // Linear increment wrapping modulo the RAM depth.
    assign memAddr     = base_q + MEM_ADDR_WIDTH'(beatCnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            burstCmd_q <= CMD_IDLE;
            base_q     <= '0;
            beatCnt_q  <= '0;
            gapCnt_q   <= '0;
            waitCnt_q  <= '0;
            refCyc_q   <= '0;
        end else begin
            state_q    <= state_d;
            burstCmd_q <= burstCmd_d;
            base_q     <= base_d;
            beatCnt_q  <= beatCnt_d;
            gapCnt_q   <= gapCnt_d;
            waitCnt_q  <= waitCnt_d;
            refCyc_q   <= refCyc_d;
        end
    end

    // Free-running refresh timer. A new request wins over a clear in the same
    // cycle so no refresh is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refCnt_q     <= '0;
            refPending_q <= 1'b0;
        end else if (refCnt_q == REF_W'(REFRESH_INTERVAL - 1)) begin
            refCnt_q     <= '0;
            refPending_q <= 1'b1;
        end else begin
            refCnt_q <= refCnt_q + 1'b1;
            if (clearPending) begin
                refPending_q <= 1'b0;
            end
        end
    end

    // Pulses are decoded from the current state and the live command, so an
    // abort suppresses the pulse (and the RAM write) in the abort cycle itself.
    // Reads are issued one cycle ahead of each beat to cover the RAM latency.
    always_comb begin
        state_d      = state_q;
        burstCmd_d   = burstCmd_q;
        base_d       = base_q;
        beatCnt_d    = beatCnt_q;
        gapCnt_d     = gapCnt_q;
        waitCnt_d    = waitCnt_q;
        refCyc_d     = refCyc_q;
        clearPending = 1'b0;
        ramWrEn      = 1'b0;
        ramRdEn      = 1'b0;
        ramRdAddr    = memAddr;
        doneOut      = 1'b0;
        validOut     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (refPending_q) begin
                    state_d  = ST_REFRESH;
                    refCyc_d = '0;
                end else if (cmdIn == CMD_WRITE || cmdIn == CMD_READ) begin
                    base_d     = data_address[MEM_ADDR_WIDTH-1:0];
                    burstCmd_d = cmdIn;
                    beatCnt_d  = '0;
                    gapCnt_d   = '0;
                    waitCnt_d  = '0;
                    state_d    = (cmdIn == CMD_WRITE) ? ST_WRITE : ST_READ_WAIT;
                end
            end

            ST_WRITE: begin
                if (!burstActive) begin
                    state_d = ST_IDLE;
                end else if (gapCnt_q == GAP_W'(WRITE_GAP - 1)) begin
                    doneOut   = 1'b1;
                    ramWrEn   = 1'b1;
                    gapCnt_d  = '0;
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (beatCnt_q == BEAT_W'(WRITE_BURST_LENGTH - 1)) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end

            ST_READ_WAIT: begin
                if (!burstActive) begin
                    state_d = ST_IDLE;
                end else if (waitCnt_q == WAIT_W'(READ_LATENCY - 2)) begin
                    ramRdEn = 1'b1;
                    state_d = ST_READ;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end

            ST_READ: begin
                if (!burstActive) begin
                    state_d = ST_IDLE;
                end else begin
                    validOut = 1'b1;
                    if (beatCnt_q == BEAT_W'(READ_BURST_LENGTH - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                        ramRdEn   = 1'b1;
                        ramRdAddr = memAddr + 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (!burstActive) begin
                    state_d = ST_IDLE;
                end
            end

            ST_REFRESH: begin
                if (refCyc_q == RCY_W'(REFRESH_CYCLES - 1)) begin
                    clearPending = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    refCyc_d = refCyc_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    burst_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (ramWrEn),
        .wr_addr_i(memAddr),
        .wr_data_i(data_write),
        .rd_en_i  (ramRdEn),
        .rd_addr_i(ramRdAddr),
        .rd_data_o(data_read)
    );

    assign data_read_valid = validOut;
    assign data_write_done = doneOut;
    assign refresh_active  = (state_q == ST_REFRESH);

endmodule
